div_issue_ctrl: RTL and testbench
=================================

Name: div_issue_ctrl

Overview:
- Issue/stall controller in the execute stage, directly upstream of the iterative radix-2 divider.
- Accepts a one-cycle divide request from the EX decode and drives the divider's level-sensitive interface: operands, op and valid are held stable until the divider returns ready.
- Stalls the pipeline while the divide runs, then issues a single write-back pulse.
- Handles flush/cancel and x0 destinations.

Parameters:
- WIDTH, 32, data width of operands and result.
- REG_AW, 5, register-file address width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_i  in  1  EX stage presents a M-extension op this cycle
- op_i  in  3  funct3: DIV=3'b100, DIVU=3'b101, REM=3'b110, REMU=3'b111; op_i[2]=0 means not a divide
- dividend_i  in  WIDTH  rs1 value
- divisor_i  in  WIDTH  rs2 value
- rd_addr_i  in  REG_AW  destination register
- flush_i  in  1  pipeline flush (jump/interrupt); cancels any in-flight divide
- busy_o  out  1  stall request to the pipeline/hold controller
- div_valid_o  out  1  to divider valid input; level, held for the whole operation
- div_dividend_o  out  WIDTH  latched dividend
- div_divisor_o  out  WIDTH  latched divisor
- div_op_o  out  3  latched op
- div_data_i  in  WIDTH  divider result
- div_ready_i  in  1  divider done, registered
- wb_we_o  out  1  write-back enable, one-cycle pulse
- wb_addr_o  out  REG_AW  write-back address
- wb_data_o  out  WIDTH  write-back data

Behaviour:
- Reset (rst_i=1 at a clock edge, including mid-operation) forces:
  - state IDLE
  - div_valid_o=0, wb_we_o=0
  - all latched operand, op, address and data registers = 0
- Reset mid-operation discards the request with no write-back.
- accept = req_i & op_i[2] & (rd_addr_i!=0) & ~flush_i & (state==IDLE).
- busy_o = accept | (state!=IDLE). busy_o is combinational so the requesting instruction is stalled in its issue cycle.
- State IDLE:
  - On accept: latch dividend, divisor, op and rd; div_valid_o<=1; go to RUN.
  - req_i with op_i[2]=0: ignored.
  - req_i with rd_addr_i==0: dropped; no divider activity, no stall, no write-back.
  - div_ready_i in IDLE is ignored.
- State RUN:
  - div_valid_o=1; div_* outputs constant.
  - flush_i=1 takes priority: div_valid_o<=0 (this resets the divider), go to IDLE, no write-back.
  - Otherwise, on div_ready_i=1: latch div_data_i into wb_data_o, div_valid_o<=0, go to WB.
- State WB:
  - wb_we_o=1 for exactly one cycle; wb_addr_o = latched rd; busy_o=1.
  - flush_i=1 in this cycle suppresses wb_we_o.
  - Always go to IDLE next.
  - A new request can be accepted only from IDLE, i.e. no earlier than the cycle after WB.
- div_valid_o drops in the cycle after div_ready_i is seen, so the divider returns to idle and never re-launches.
- Latency, with accept in cycle T0:
  - div_valid_o high from T1.
  - Normal op: divider ready at T35, WB at T36, busy_o low from T37.
  - Divide-by-zero and overflow (0x8000_0000 / -1): ready at T3, WB at T4.
- Result values (zero-divide and overflow conventions) are the divider's. This block forwards div_data_i unmodified.
- wb_addr_o and wb_data_o hold their last values outside WB; only wb_we_o qualifies them.

Test Plan:
- DIVU 100/7, rd=5 at T0 -> busy_o high T0..T36; wb_we_o=1 only at T36; wb_addr_o=5; wb_data_o=14; div_valid_o high T1..T35.
- REM 0xFFFF_FFF9 (-7) % 2, rd=3 -> wb_data_o=0xFFFF_FFFF at T36; DIV same operands -> 0xFFFF_FFFD.
- DIV 1234/0 -> wb_data_o=0xFFFF_FFFF at T4. REMU 1234/0 -> 1234. DIV 0x8000_0000/0xFFFF_FFFF -> 0x8000_0000 at T4.
- Flush during RUN:
  - DIVU issued at T0, flush_i at T10 -> div_valid_o=0 at T11, no wb_we_o ever, busy_o low T11.
  - New DIVU 9/3 at T11 -> wb_data_o=3 at T47.
- Non-accepted requests:
  - req_i with rd=0 -> busy_o=0, div_valid_o stays 0, no write-back.
  - req_i with op_i=3'b000 -> ignored.
- Reset and overlapping requests:
  - rst_i asserted at T20 of a running op -> outputs cleared at T21, no write-back.
  - Back-to-back requests -> second accepted only at T37.

Source files
------------

// File: rtl/div_issue_ctrl_if.sv
// Level-sensitive link between the issue controller (master) and the
// iterative divider (slave). Member names follow the controller's view.
interface div_issue_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             div_valid_o;
  logic [WIDTH-1:0] div_dividend_o;
  logic [WIDTH-1:0] div_divisor_o;
  logic [2:0]       div_op_o;
  logic [WIDTH-1:0] div_data_i;
  logic             div_ready_i;

  modport master (
    output div_valid_o, div_dividend_o, div_divisor_o, div_op_o,
    input  div_data_i, div_ready_i
  );

  modport slave (
    input  div_valid_o, div_dividend_o, div_divisor_o, div_op_o,
    output div_data_i, div_ready_i
  );
endinterface

// File: rtl/div_issue_ctrl.sv
// Execute-stage issue/stall controller for the iterative divider: holds the
// divider request stable, stalls the pipe, and emits one write-back pulse.
module div_issue_ctrl #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic [2:0]        op_i,
  input  logic [WIDTH-1:0]  dividend_i,
  input  logic [WIDTH-1:0]  divisor_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  input  logic              flush_i,
  output logic              busy_o,
  div_issue_ctrl_if.master  div,
  output logic              wb_we_o,
  output logic [REG_AW-1:0] wb_addr_o,
  output logic [WIDTH-1:0]  wb_data_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WB   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               valid_q, valid_d;
  logic [WIDTH-1:0]   dividend_q, dividend_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic [2:0]         op_q, op_d;
  logic [REG_AW-1:0]  rd_q, rd_d;
  logic [WIDTH-1:0]   wb_data_q, wb_data_d;
  logic               accept;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      dividend_q <= '0;
      divisor_q  <= '0;
      op_q       <= '0;
      rd_q       <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    op_d       = op_q;
    rd_d       = rd_q;
    wb_data_d  = wb_data_q;

    // x0 destinations and non-divide funct3 never reach the divider
    accept = req_i & op_i[2] & (rd_addr_i != '0) & ~flush_i & (state_q == IDLE);

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          dividend_d = dividend_i;
          divisor_d  = divisor_i;
          op_d       = op_i;
          rd_d       = rd_addr_i;
          valid_d    = 1'b1;
          state_d    = RUN;
        end
      end
      RUN: begin
        // Dropping valid on flush is what resets the divider
        if (flush_i) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end else if (div.div_ready_i) begin
          wb_data_d = div.div_data_i;
          valid_d   = 1'b0;
          state_d   = WB;
        end
      end
      WB: begin
        state_d = IDLE;
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase

    busy_o  = accept | (state_q != IDLE);
    wb_we_o = (state_q == WB) & ~flush_i;
  end

  assign div.div_valid_o    = valid_q;
  assign div.div_dividend_o = dividend_q;
  assign div.div_divisor_o  = divisor_q;
  assign div.div_op_o       = op_q;
  assign wb_addr_o          = rd_q;
  assign wb_data_o          = wb_data_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a behavioural divider whose result
// and latency are set per test.
module tb_div_issue_ctrl;
  localparam int WIDTH  = 32;
  localparam int REG_AW = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req = 1'b0;
  logic [2:0]        op = 3'b011;
  logic [WIDTH-1:0]  dividend = '0;
  logic [WIDTH-1:0]  divisor = '0;
  logic [REG_AW-1:0] rd = '0;
  logic              flush = 1'b0;
  logic              busy;
  logic              wb_we;
  logic [REG_AW-1:0] wb_addr;
  logic [WIDTH-1:0]  wb_data;

  int n_tests = 0;
  int n_fail  = 0;

  logic [WIDTH-1:0] div_res = '0;
  int               div_lat = 35;
  int               cnt = 0;
  logic             rdy = 1'b0;

  div_issue_ctrl_if #(.WIDTH(WIDTH)) dif ();

  div_issue_ctrl #(.WIDTH(WIDTH), .REG_AW(REG_AW)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_i      (req),
    .op_i       (op),
    .dividend_i (dividend),
    .divisor_i  (divisor),
    .rd_addr_i  (rd),
    .flush_i    (flush),
    .busy_o     (busy),
    .div        (dif.master),
    .wb_we_o    (wb_we),
    .wb_addr_o  (wb_addr),
    .wb_data_o  (wb_data)
  );

  always #5 clk = ~clk;

  // Divider model: registered ready pulse in the lat-th cycle of valid;
  // data is garbage except while ready is high.
  always @(posedge clk) begin
    if (rst || !dif.div_valid_o) begin
      cnt <= 0;
      rdy <= 1'b0;
    end else begin
      cnt <= cnt + 1;
      rdy <= (cnt == div_lat - 2);
    end
  end
  assign dif.div_ready_i = rdy;
  assign dif.div_data_i  = rdy ? div_res : ~div_res;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    req      = 1'b0;
    op       = 3'b011;
    dividend = 32'hDEAD_BEEF;
    divisor  = 32'h0BAD_F00D;
    rd       = 5'd31;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] r);
    req = 1'b1; op = o; dividend = a; divisor = b; rd = r;
  endtask

  // Full operation from T0 (current cycle) through the cycle after write-back.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] r,
                        input logic [31:0] res, input int lat, input logic [31:0] exp);
    logic ok;
    div_res = res;
    div_lat = lat;
    issue(o, a, b, r);
    #1;
    check({tag, " busy@T0"}, {31'd0, busy}, 32'd1);
    tick();
    idle_inputs();
    check({tag, " valid@T1"}, {31'd0, dif.div_valid_o}, 32'd1);
    check({tag, " dividend latched"}, dif.div_dividend_o, a);
    check({tag, " divisor latched"}, dif.div_divisor_o, b);
    check({tag, " op latched"}, {29'd0, dif.div_op_o}, {29'd0, o});
    ok = 1'b1;
    for (int c = 1; c <= lat; c++) begin
      if (!busy || wb_we || !dif.div_valid_o || dif.div_dividend_o !== a) ok = 1'b0;
      tick();
    end
    check({tag, " hold during run"}, {31'd0, ok}, 32'd1);
    check({tag, " wb_we@WB"}, {31'd0, wb_we}, 32'd1);
    check({tag, " wb_addr"}, {27'd0, wb_addr}, {27'd0, r});
    check({tag, " wb_data"}, wb_data, exp);
    check({tag, " busy@WB"}, {31'd0, busy}, 32'd1);
    check({tag, " valid@WB"}, {31'd0, dif.div_valid_o}, 32'd0);
    tick();
    check({tag, " wb_we after"}, {31'd0, wb_we}, 32'd0);
    check({tag, " busy after"}, {31'd0, busy}, 32'd0);
    check({tag, " wb_data held"}, wb_data, exp);
  endtask

  task automatic quiet(input string tag, input int n);
    logic ok;
    ok = 1'b1;
    for (int c = 0; c < n; c++) begin
      if (wb_we || busy || dif.div_valid_o) ok = 1'b0;
      tick();
    end
    check({tag, " quiet"}, {31'd0, ok}, 32'd1);
  endtask

  initial begin
    logic ok;
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    check("reset valid", {31'd0, dif.div_valid_o}, 32'd0);
    check("reset wb_we", {31'd0, wb_we}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset dividend", dif.div_dividend_o, 32'd0);
    check("reset wb_data", wb_data, 32'd0);
    rst = 1'b0;
    tick();

    run_op("DIVU100/7", 3'b101, 32'd100, 32'd7, 5'd5, 32'd14, 35, 32'd14);
    run_op("REM-7%2", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFF, 35, 32'hFFFF_FFFF);
    run_op("DIV-7/2", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFD, 35, 32'hFFFF_FFFD);
    run_op("DIV/0", 3'b100, 32'd1234, 32'd0, 5'd7, 32'hFFFF_FFFF, 3, 32'hFFFF_FFFF);
    run_op("REMU/0", 3'b111, 32'd1234, 32'd0, 5'd8, 32'd1234, 3, 32'd1234);
    run_op("DIVovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h8000_0000, 3, 32'h8000_0000);

    // Non-accepted requests
    issue(3'b101, 32'd10, 32'd2, 5'd0);
    #1;
    check("rd0 busy", {31'd0, busy}, 32'd0);
    tick();
    idle_inputs();
    quiet("rd0", 40);
    issue(3'b000, 32'd10, 32'd2, 5'd7);
    #1;
    check("op000 busy", {31'd0, busy}, 32'd0);
    tick();
    idle_inputs();
    quiet("op000", 5);
    issue(3'b101, 32'd10, 32'd2, 5'd7);
    flush = 1'b1;
    #1;
    check("flush idle busy", {31'd0, busy}, 32'd0);
    tick();
    idle_inputs();
    flush = 1'b0;
    quiet("flush idle", 40);

    // Flush during RUN at T10, new request at T11
    div_res = 32'd10; div_lat = 35;
    issue(3'b101, 32'd50, 32'd5, 5'd4);
    tick();
    idle_inputs();
    for (int c = 1; c < 10; c++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush valid@T11", {31'd0, dif.div_valid_o}, 32'd0);
    check("flush busy@T11", {31'd0, busy}, 32'd0);
    check("flush wb_we@T11", {31'd0, wb_we}, 32'd0);
    run_op("DIVU9/3", 3'b101, 32'd9, 32'd3, 5'd6, 32'd3, 35, 32'd3);

    // Flush in the write-back cycle suppresses the pulse
    div_res = 32'hFFFF_FFFF; div_lat = 3;
    issue(3'b100, 32'd77, 32'd0, 5'd10);
    tick();
    idle_inputs();
    for (int c = 1; c <= 3; c++) tick();
    flush = 1'b1;
    #1;
    check("flushWB wb_we", {31'd0, wb_we}, 32'd0);
    check("flushWB wb_data", wb_data, 32'hFFFF_FFFF);
    tick();
    flush = 1'b0;
    check("flushWB busy after", {31'd0, busy}, 32'd0);

    // Reset at T20 of a running op
    div_res = 32'd5; div_lat = 35;
    issue(3'b101, 32'd25, 32'd5, 5'd11);
    tick();
    idle_inputs();
    for (int c = 1; c < 20; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst valid@T21", {31'd0, dif.div_valid_o}, 32'd0);
    check("rst dividend@T21", dif.div_dividend_o, 32'd0);
    check("rst divisor@T21", dif.div_divisor_o, 32'd0);
    check("rst op@T21", {29'd0, dif.div_op_o}, 32'd0);
    check("rst wb_addr@T21", {27'd0, wb_addr}, 32'd0);
    check("rst wb_data@T21", wb_data, 32'd0);
    quiet("after rst", 40);

    // Back-to-back: request held high, second accepted only at T37
    div_res = 32'd14; div_lat = 35;
    issue(3'b101, 32'd100, 32'd7, 5'd5);
    tick();
    issue(3'b101, 32'd81, 32'd9, 5'd6);
    ok = 1'b1;
    for (int c = 1; c <= 35; c++) begin
      if (!busy || wb_we || dif.div_dividend_o !== 32'd100) ok = 1'b0;
      tick();
    end
    check("b2b first held", {31'd0, ok}, 32'd1);
    check("b2b wb_we@T36", {31'd0, wb_we}, 32'd1);
    check("b2b wb_data@T36", wb_data, 32'd14);
    div_res = 32'd9;
    tick();
    check("b2b busy@T37", {31'd0, busy}, 32'd1);
    check("b2b valid@T37", {31'd0, dif.div_valid_o}, 32'd0);
    tick();
    idle_inputs();
    check("b2b valid@T38", {31'd0, dif.div_valid_o}, 32'd1);
    check("b2b second dividend", dif.div_dividend_o, 32'd81);
    for (int c = 1; c <= 35; c++) tick();
    check("b2b second wb_we", {31'd0, wb_we}, 32'd1);
    check("b2b second wb_addr", {27'd0, wb_addr}, 32'd6);
    check("b2b second wb_data", wb_data, 32'd9);
    tick();
    check("b2b done busy", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
